// File: rtl/uart_rx_if.sv
// Receive-side bundle of the 8N1 UART receiver: received byte, its strobes and busy.
// The master drives the bundle; the slave is the consuming core.
interface uart_rx_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  modport master (
    output rx_byte,
    output rx_valid,
    output frame_err,
    output busy
  );

  modport slave (
    input rx_byte,
    input rx_valid,
    input frame_err,
    input busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, falling-edge start detection,
// midpoint sampling of every bit, one-cycle byte/framing-error strobes.
module uart_rx #(
  parameter int CLOCK_FREQ = 60000000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  uart_rx_if.master bus
);

  localparam int BIT_PERIOD  = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_PERIOD = BIT_PERIOD / 2;
  localparam logic [15:0] BIT_LAST  = 16'(BIT_PERIOD - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
    STOP_BIT   = 3'd3,
    BREAK_WAIT = 3'd4
  } state_t;

  state_t      state_reg;
  logic        s1_reg;
  logic        s2_reg;
  logic        s2_d_reg;
  logic [1:0]  sync_fill_reg;
  logic        line_armed_reg;
  logic [15:0] baud_cnt_reg;
  logic [2:0]  bit_cnt_reg;
  logic [7:0]  shift_reg;
  logic [7:0]  rx_byte_reg;
  logic        rx_valid_reg;
  logic        frame_err_reg;
  logic        busy_reg;

  logic fall_edge;

  // The synchroniser resets to idle-high, so a line held low across reset would
  // look like a falling edge; starts are only armed once s2 has truly seen rx high.
  assign fall_edge = line_armed_reg & s2_d_reg & ~s2_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      s1_reg         <= 1'b1;
      s2_reg         <= 1'b1;
      s2_d_reg       <= 1'b1;
      sync_fill_reg  <= 2'b00;
      line_armed_reg <= 1'b0;
      baud_cnt_reg   <= 16'd0;
      bit_cnt_reg    <= 3'd0;
      shift_reg      <= 8'd0;
      rx_byte_reg    <= 8'd0;
      rx_valid_reg   <= 1'b0;
      frame_err_reg  <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      s1_reg        <= rx;
      s2_reg        <= s1_reg;
      s2_d_reg      <= s2_reg;
      sync_fill_reg <= {sync_fill_reg[0], 1'b1};
      if (sync_fill_reg[1] && s2_reg) begin
        line_armed_reg <= 1'b1;
      end

      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          busy_reg     <= 1'b0;
          baud_cnt_reg <= 16'd0;
          bit_cnt_reg  <= 3'd0;
          if (fall_edge) begin
            state_reg <= START_BIT;
            busy_reg  <= 1'b1;
          end
        end

        START_BIT: begin
          if (baud_cnt_reg == HALF_LAST) begin
            baud_cnt_reg <= 16'd0;
            if (!s2_reg) begin
              state_reg <= DATA_BITS;
            end else begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 16'd1;
          end
        end

        DATA_BITS: begin
          if (baud_cnt_reg == BIT_LAST) begin
            baud_cnt_reg <= 16'd0;
            // LSB arrives first: shift right so it settles in bit 0.
            shift_reg    <= {s2_reg, shift_reg[7:1]};
            bit_cnt_reg  <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              state_reg <= STOP_BIT;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 16'd1;
          end
        end

        STOP_BIT: begin
          if (baud_cnt_reg == BIT_LAST) begin
            baud_cnt_reg <= 16'd0;
            if (s2_reg) begin
              rx_byte_reg  <= shift_reg;
              rx_valid_reg <= 1'b1;
              state_reg    <= IDLE;
              busy_reg     <= 1'b0;
            end else begin
              frame_err_reg <= 1'b1;
              state_reg     <= BREAK_WAIT;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 16'd1;
          end
        end

        BREAK_WAIT: begin
          baud_cnt_reg <= 16'd0;
          bit_cnt_reg  <= 3'd0;
          if (s2_reg) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end

        default: begin
          state_reg    <= IDLE;
          busy_reg     <= 1'b0;
          baud_cnt_reg <= 16'd0;
          bit_cnt_reg  <= 3'd0;
        end
      endcase
    end
  end

  assign bus.rx_byte   = rx_byte_reg;
  assign bus.rx_valid  = rx_valid_reg;
  assign bus.frame_err = frame_err_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit: directed corner cases,
// a vector table and randomized frames against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx;

  logic clk;
  logic rst;
  logic rx;

  uart_rx_if bus ();

  uart_rx #(
    .CLOCK_FREQ(160),
    .BAUD_RATE (10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx (rx),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ferr_cnt = 0;
  logic [7:0] valid_q[$];
  int valid_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Strobe monitor, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (bus.rx_valid) begin
      valid_q.push_back(bus.rx_byte);
      valid_cyc_q.push_back(cyc);
    end
    if (bus.frame_err) ferr_cnt <= ferr_cnt + 1;
    if (bus.rx_valid || bus.frame_err)
      chk("strobe_exclusive", int'(bus.rx_valid & bus.frame_err), 0);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  // hp = half-clocks per bit; a low stop bit is followed by hold extra low clocks.
  task automatic send_frame(input logic [7:0] data, input bit stop_ok, input int hp, input int hold);
    rx = 1'b0;
    #(hp * 5);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      #(hp * 5);
    end
    rx = stop_ok;
    #(hp * 5);
    if (!stop_ok) #(hold * 10);
    rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         hp;
    logic [7:0] exp_byte;
    int         exp_valid;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n0, f0, fall_cyc, hi_cyc, dly, g_cyc;
    bit saw_busy, done;
    logic [7:0] model_byte;

    vecs[0] = '{8'h96, 1'b1, 31, 8'h96, 1, 0};
    vecs[1] = '{8'h96, 1'b1, 33, 8'h96, 1, 0};
    vecs[2] = '{8'h5A, 1'b1, 32, 8'h5A, 1, 0};
    vecs[3] = '{8'hC3, 1'b0, 32, 8'h5A, 0, 1};
    vecs[4] = '{8'h01, 1'b1, 31, 8'h01, 1, 0};
    vecs[5] = '{8'h80, 1'b1, 33, 8'h80, 1, 0};
    vecs[6] = '{8'h7E, 1'b0, 33, 8'h80, 0, 1};

    rst = 1'b0;
    rx  = 1'b1;
    #12;
    chk("reset_rx_byte", int'(bus.rx_byte), 0);
    chk("reset_rx_valid", int'(bus.rx_valid), 0);
    chk("reset_frame_err", int'(bus.frame_err), 0);
    chk("reset_busy", int'(bus.busy), 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    idle(20);

    // Single frame with latency measurement.
    n0 = valid_q.size(); f0 = ferr_cnt; fall_cyc = cyc;
    send_frame(8'hA5, 1'b1, 32, 0);
    idle(6);
    chk("single_valid_count", valid_q.size() - n0, 1);
    chk("single_ferr_count", ferr_cnt - f0, 0);
    chk("single_rx_byte", int'(bus.rx_byte), 8'hA5);
    chk("single_busy_after", int'(bus.busy), 0);
    if (valid_q.size() > n0)
      chk_range("single_latency", valid_cyc_q[n0] - fall_cyc, 153, 157);
    $display("frame A5 single: rx_byte=%02h", bus.rx_byte);

    // Back-to-back frames, one stop bit each.
    idle(20);
    n0 = valid_q.size();
    send_frame(8'h00, 1'b1, 32, 0);
    send_frame(8'hFF, 1'b1, 32, 0);
    send_frame(8'h55, 1'b1, 32, 0);
    idle(6);
    chk("b2b_valid_count", valid_q.size() - n0, 3);
    if (valid_q.size() >= n0 + 3) begin
      chk("b2b_byte0", int'(valid_q[n0]), 8'h00);
      chk("b2b_byte1", int'(valid_q[n0 + 1]), 8'hFF);
      chk("b2b_byte2", int'(valid_q[n0 + 2]), 8'h55);
      chk("b2b_spacing01", valid_cyc_q[n0 + 1] - valid_cyc_q[n0], 160);
      chk("b2b_spacing12", valid_cyc_q[n0 + 2] - valid_cyc_q[n0 + 1], 160);
    end
    $display("frames 00 FF 55 back-to-back: %0d strobes", valid_q.size() - n0);

    // Low stop bit followed by a 100-clock break.
    idle(20);
    n0 = valid_q.size(); f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 32, 100);
    hi_cyc = cyc;
    chk("break_busy_held", int'(bus.busy), 1);
    done = 0; dly = -1;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (!bus.busy) begin done = 1; dly = cyc - hi_cyc; end
    end
    chk_range("break_busy_release", dly, 1, 3);
    idle(4);
    chk("break_ferr_count", ferr_cnt - f0, 1);
    chk("break_valid_count", valid_q.size() - n0, 0);
    chk("break_rx_byte_kept", int'(bus.rx_byte), 8'h55);
    $display("frame 3C break: ferr=%0d busy_release=%0d", ferr_cnt - f0, dly);

    // 4-clock glitch on an idle line.
    idle(20);
    n0 = valid_q.size(); f0 = ferr_cnt; g_cyc = cyc;
    rx = 1'b0; #40; rx = 1'b1;
    saw_busy = 0; done = 0; dly = -1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.busy) saw_busy = 1;
      else if (saw_busy) begin done = 1; dly = cyc - g_cyc; end
    end
    chk("glitch_busy_seen", int'(saw_busy), 1);
    chk_range("glitch_busy_release", dly, 1, 12);
    idle(4);
    chk("glitch_no_valid", valid_q.size() - n0, 0);
    chk("glitch_no_ferr", ferr_cnt - f0, 0);
    $display("glitch 4 clk: busy_release=%0d", dly);

    // Reset during bit 4 of 0x81, released with rx still low.
    idle(20);
    n0 = valid_q.size();
    rx = 1'b0; #160;
    for (int i = 0; i < 4; i++) begin
      rx = ((i == 0) ? 1'b1 : 1'b0);
      #160;
    end
    rx = 1'b0; #80;
    chk("midrst_busy_before", int'(bus.busy), 1);
    rst = 1'b0;
    #1;
    chk("midrst_rx_byte", int'(bus.rx_byte), 0);
    chk("midrst_rx_valid", int'(bus.rx_valid), 0);
    chk("midrst_frame_err", int'(bus.frame_err), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("low_after_reset_no_start", int'(bus.busy), 0);
    rx = 1'b1;
    idle(20);
    send_frame(8'h81, 1'b1, 32, 0);
    idle(6);
    chk("midrst_valid_count", valid_q.size() - n0, 1);
    chk("midrst_rx_byte_after", int'(bus.rx_byte), 8'h81);
    $display("frame 81 after mid-frame reset: rx_byte=%02h", bus.rx_byte);

    // Vector table, including +/-3%% bit period.
    foreach (vecs[k]) begin
      idle(10);
      n0 = valid_q.size(); f0 = ferr_cnt;
      send_frame(vecs[k].data, vecs[k].stop_ok, vecs[k].hp, 5);
      idle(5);
      chk("vec_valid_count", valid_q.size() - n0, vecs[k].exp_valid);
      chk("vec_ferr_count", ferr_cnt - f0, vecs[k].exp_ferr);
      chk("vec_rx_byte", int'(bus.rx_byte), int'(vecs[k].exp_byte));
      chk("vec_busy", int'(bus.busy), 0);
      $display("vec %0d data=%02h stop=%0d hp=%0d rx_byte=%02h", k, vecs[k].data,
               vecs[k].stop_ok, vecs[k].hp, bus.rx_byte);
    end

    // Randomized frames against a frame-level model: good frames update the
    // byte and strobe valid, bad stop bits strobe frame_err and keep the byte.
    model_byte = bus.rx_byte;
    for (int k = 0; k < 20; k++) begin
      logic [7:0] d;
      bit ok;
      int hp;
      d  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 3) != 0);
      hp = $urandom_range(31, 33);
      idle($urandom_range(4, 10));
      n0 = valid_q.size(); f0 = ferr_cnt;
      send_frame(d, ok, hp, $urandom_range(0, 20));
      if (ok) model_byte = d;
      idle(5);
      chk("rand_valid_count", valid_q.size() - n0, ok ? 1 : 0);
      chk("rand_ferr_count", ferr_cnt - f0, ok ? 0 : 1);
      chk("rand_rx_byte", int'(bus.rx_byte), int'(model_byte));
      $display("rand %0d data=%02h stop=%0d hp=%0d rx_byte=%02h", k, d, ok, hp, bus.rx_byte);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; companion to the existing transmitter, with the same baud/clock parameters.
- Sits on the serial input pin and delivers received bytes to the core.
- Synchronises the asynchronous line, detects the start bit and samples each bit at its midpoint.
- Presents each byte with a one-cycle valid strobe and flags framing errors.

Parameters:
- CLOCK_FREQ, 60000000: system clock frequency in Hz.
- BAUD_RATE, 9600: serial bit rate.
- BIT_PERIOD, CLOCK_FREQ/BAUD_RATE (6250 at defaults): clocks per bit. Derived localparam.
- HALF_PERIOD, BIT_PERIOD/2: clocks from start-edge detection to the start-bit midpoint. Derived localparam.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- rx  input  1  serial line; asynchronous to clk; idles high.
- rx_byte  output  8  last correctly framed byte; LSB received first.
- rx_valid  output  1  one-cycle strobe: rx_byte updated this cycle.
- frame_err  output  1  one-cycle strobe: stop bit sampled low.
- busy  output  1  high from start-bit acceptance until return to IDLE.

Behaviour:
- Reset values (asserted asynchronously while rst=0):
  - rx_byte=0, rx_valid=0, frame_err=0, busy=0, state=IDLE.
  - Synchroniser flops = 1; baud counter = 0; bit counter = 0; shift register = 0.
- Synchroniser: two flops (rx -> s1 -> s2). All decisions use s2 only. Edge detection compares s2 with its previous value (s2_d).
- Baud counter: wide enough for BIT_PERIOD-1 (16 bits). Cleared on every state transition. Bit counter: 3 bits.
- States:
  - IDLE: busy=0, counters cleared. On s2_d=1 and s2=0 (falling edge) -> START_BIT, busy=1.
  - START_BIT: count to HALF_PERIOD-1, then sample s2.
    - s2=0: -> DATA_BITS, counter cleared.
    - s2=1: glitch. -> IDLE, busy=0, no strobes.
  - DATA_BITS: count to BIT_PERIOD-1, then sample s2 into shift register MSB, shifting right, so the first data bit ends in bit 0.
    - After 8 samples (bit counter wraps 7->0) -> STOP_BIT.
  - STOP_BIT: count to BIT_PERIOD-1, then sample s2.
    - s2=1: rx_byte<=shift register, rx_valid=1 for exactly one cycle, -> IDLE.
    - s2=0: frame_err=1 for one cycle, rx_byte unchanged, -> BREAK_WAIT.
  - BREAK_WAIT: busy stays 1. Remains until s2=1, then -> IDLE. A held-low line (break) produces exactly one frame_err and no re-triggering.
- Sample timing: every bit is sampled HALF_PERIOD + n*BIT_PERIOD clocks after edge detection (+/-1 clock).
- Latency:
  - Edge detection occurs 2-3 clocks after the rx falling edge.
  - rx_valid asserts the clock after the stop-bit sample, about 9.5*BIT_PERIOD + 3 clocks after the rx falling edge.
- rx_valid and frame_err are never high together. Both are 0 in every state except on the cycle after the stop sample.
- rx_byte holds its value until the next good frame; no consumer handshake. A byte not captured before the next rx_valid is lost; no overrun flag.
- A falling edge in IDLE on the cycle after returning from STOP_BIT is accepted, so back-to-back frames with a single stop bit are supported.
- rx activity outside IDLE and BREAK_WAIT is not edge-checked; only midpoint samples matter.
- Reset mid-frame: immediate return to IDLE with all outputs at reset values. A partial frame yields no strobe.
- After reset deasserts with rx low, no start is detected until rx has been seen high and then falls.
- Unused state encodings -> IDLE, busy=0.

Test Plan:
Bench uses CLOCK_FREQ=160, BAUD_RATE=10 (BIT_PERIOD=16, HALF_PERIOD=8).
- Single frame 0xA5, one stop bit -> one rx_valid pulse about 155 clocks after the start edge; rx_byte=0xA5; frame_err never high; busy low after.
- Back-to-back frames 0x00, 0xFF, 0x55 with no idle gap -> three rx_valid pulses, 160 clocks apart; rx_byte sequence 0x00, 0xFF, 0x55.
- Frame 0x3C with stop bit driven low, then line held low 100 clocks, then high -> one frame_err pulse; no rx_valid; rx_byte keeps its prior value; busy falls 1-3 clocks after rx returns high.
- Low glitch of 4 clocks on idle line -> START_BIT entered then abandoned; no rx_valid or frame_err; busy back to 0 within 12 clocks.
- rst driven low during bit 4 of frame 0x81 -> all outputs 0 immediately. After release, a following clean frame 0x81 is received correctly with rx_valid=1.
- Baud tolerance: frame 0x96 sent at +/-3% bit period (15.5 and 16.5 clocks per bit) -> rx_byte=0x96, rx_valid=1 in both cases.
